// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one 32-bit memory port between an instruction-fetch
//             requester (port 0) and a load/store requester (port 1). Grants
//             one transaction at a time, drives the owner select for the
//             external address/wdata muxes and sequences the mem_req/mem_ready
//             handshake, returning a done pulse plus captured read data.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             p0_req/p0_we/p0_done - port 0 request, write enable, done pulse
//             p1_req/p1_we/p1_done - port 1 request, write enable, done pulse
//             rsp_rdata            - read data returned with done
//             mux_sel              - owner select (0 = port 0, 1 = port 1)
//             mem_req/mem_we       - memory request and write enable
//             mem_ready/mem_rdata  - memory completion and read data
//             arb_busy             - FSM not in IDLE
//             arb_timeout          - abort pulse (0 unless timeout built)
//  Options  : ARB_TIMEOUT_EN - build the BUSY watchdog that aborts after
//             TIMEOUT_CYCLES cycles without mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int PRIO_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic        p1_we,
    output logic        p1_done,
    output logic [31:0] rsp_rdata,
    output logic        mux_sel,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        arb_busy,
    output logic        arb_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_gnt;
    logic        r_mux_sel;
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_p0_done;
    logic        r_p1_done;
    logic        r_busy;
    logic [31:0] r_rsp_rdata;
    logic        w_grant_p1;

    // Owner choice in IDLE. With both requesting, round-robin hands the port
    // to whichever side did not win last time; fixed priority favours port 1.
    always_comb begin
        w_grant_p1 = p1_req;
        if (p0_req && p1_req) begin
            w_grant_p1 = (PRIO_MODE != 0) ? 1'b1 : !r_last_gnt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_limit;

    // Counter holds the number of completed stall cycles, so it reads
    // TIMEOUT_CYCLES-1 during the last allowed BUSY cycle.
    assign w_limit     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign arb_timeout = r_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
    assign arb_timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= 1'b1;
            r_mux_sel   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_p0_done   <= 1'b0;
            r_p1_done   <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_rdata <= 32'd0;
`ifdef ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        r_mux_sel  <= w_grant_p1;
                        r_mem_we   <= w_grant_p1 ? p1_we : p0_we;
                        r_last_gnt <= w_grant_p1;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    // mem_ready is checked first so a completion on the
                    // limit cycle is treated as a normal finish.
                    if (mem_ready) begin
                        r_rsp_rdata <= mem_rdata;
                        r_mem_req   <= 1'b0;
                        r_p0_done   <= !r_mux_sel;
                        r_p1_done   <= r_mux_sel;
                        r_state     <= ST_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_limit) begin
                        r_rsp_rdata <= 32'd0;
                        r_mem_req   <= 1'b0;
                        r_p0_done   <= !r_mux_sel;
                        r_p1_done   <= r_mux_sel;
                        r_timeout   <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mux_sel   = r_mux_sel;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign p0_done   = r_p0_done;
    assign p1_done   = r_p1_done;
    assign arb_busy  = r_busy;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench. Two arbiters share every input: u_rr uses
//             round-robin, u_fp uses fixed priority. Directed scenarios check
//             spec values directly; a randomized run compares both against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, p0_req, p0_we, p1_req, p1_we, mem_ready;
    logic [31:0] mem_rdata;

    logic [1:0]  p0_done_v, p1_done_v, mux_sel_v, mem_req_v, mem_we_v;
    logic [1:0]  arb_busy_v, arb_timeout_v;
    logic [31:0] rsp_rdata_v [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance (0 = round-robin, 1 = fixed prio)
    int          m_st   [2];  // 0 idle, 1 busy, 2 resp
    int          m_sel  [2];
    int          m_we   [2];
    int          m_last [2];
    int          m_bc   [2];  // BUSY cycles spent in the current transaction
    int          m_to   [2];
    logic [31:0] m_rd   [2];

    always #5 clk = ~clk;

    mem_port_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(c_TIMEOUT), .CNT_W(5)) u_rr (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_done(p0_done_v[0]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_done(p1_done_v[0]),
        .rsp_rdata(rsp_rdata_v[0]), .mux_sel(mux_sel_v[0]),
        .mem_req(mem_req_v[0]), .mem_we(mem_we_v[0]),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy_v[0]), .arb_timeout(arb_timeout_v[0])
    );

    mem_port_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(c_TIMEOUT), .CNT_W(5)) u_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_done(p0_done_v[1]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_done(p1_done_v[1]),
        .rsp_rdata(rsp_rdata_v[1]), .mux_sel(mux_sel_v[1]),
        .mem_req(mem_req_v[1]), .mem_we(mem_we_v[1]),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy_v[1]), .arb_timeout(arb_timeout_v[1])
    );

    // {mem_req, mem_we, p0_done, p1_done, arb_busy, arb_timeout, mux_sel}
    function automatic logic [6:0] dut_flags(int i);
        return {mem_req_v[i], mem_we_v[i], p0_done_v[i], p1_done_v[i],
                arb_busy_v[i], arb_timeout_v[i], mux_sel_v[i]};
    endfunction

    function automatic logic [6:0] model_flags(int i);
        return {m_st[i] == 1, m_we[i] != 0, m_st[i] == 2 && m_sel[i] == 0,
                m_st[i] == 2 && m_sel[i] == 1, m_st[i] != 0, m_to[i] != 0,
                m_sel[i] != 0};
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        int o;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_st[i] = 0; m_sel[i] = 0; m_we[i] = 0; m_last[i] = 1;
                m_bc[i] = 0; m_to[i] = 0; m_rd[i] = 32'd0;
            end else begin
                m_to[i] = 0;
                case (m_st[i])
                    0: if (p0_req || p1_req) begin
                        if (p0_req && p1_req) o = (i == 1) ? 1 : 1 - m_last[i];
                        else                  o = p1_req ? 1 : 0;
                        m_sel[i] = o; m_last[i] = o;
                        m_we[i]  = o ? int'(p1_we) : int'(p0_we);
                        m_st[i]  = 1; m_bc[i] = 0;
                    end
                    1: begin
                        m_bc[i] = m_bc[i] + 1;
                        if (mem_ready) begin
                            m_rd[i] = mem_rdata; m_st[i] = 2;
                        end else if (c_TO_EN && m_bc[i] == c_TIMEOUT) begin
                            m_rd[i] = 32'd0; m_to[i] = 1; m_st[i] = 2;
                        end
                    end
                    default: m_st[i] = 0;
                endcase
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; mem_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (dut_flags(i) !== 7'd0) begin
                    n_err++;
                    $display("FAIL reset_flags inst%0d cyc%0d: got %b want 0000000", i, k, dut_flags(i));
                end
                n_vec++;
                if (rsp_rdata_v[i] !== 32'd0) begin
                    n_err++;
                    $display("FAIL reset_rdata inst%0d: got %h want 0", i, rsp_rdata_v[i]);
                end
            end
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({mem_req_v[0], mux_sel_v[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL first_grant_rr: got req/sel %b want 10", {mem_req_v[0], mux_sel_v[0]});
        end
        n_vec++;
        if ({mem_req_v[1], mux_sel_v[1]} !== 2'b11) begin
            n_err++;
            $display("FAIL first_grant_fp: got req/sel %b want 11", {mem_req_v[1], mux_sel_v[1]});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        p1_req = 1'b1; p1_we = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        tick();
        n_vec++;
        if (dut_flags(0) !== 7'b1000101) begin
            n_err++;
            $display("FAIL read_busy1: got %b want 1000101", dut_flags(0));
        end
        p1_req = 1'b0;  // drop after grant must be ignored
        tick();
        n_vec++;
        if (dut_flags(0) !== 7'b1000101) begin
            n_err++;
            $display("FAIL read_busy2: got %b want 1000101", dut_flags(0));
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_vec++;
        if (dut_flags(0) !== 7'b0001101) begin
            n_err++;
            $display("FAIL read_done: got %b want 0001101", dut_flags(0));
        end
        n_vec++;
        if (rsp_rdata_v[0] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL read_data: got %h want deadbeef", rsp_rdata_v[0]);
        end
        tick();
        n_vec++;
        if ({p0_done_v[0], p1_done_v[0], arb_busy_v[0]} !== 3'b000) begin
            n_err++;
            $display("FAIL read_idle: got done/busy %b want 000", {p0_done_v[0], p1_done_v[0], arb_busy_v[0]});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_done;
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mem_rdata = $urandom;
            tick();
            exp_done = 2'b00;
            if (k % 3 == 1) exp_done = ((k / 3) % 2 == 0) ? 2'b10 : 2'b01;
            n_vec++;
            if ({p0_done_v[0], p1_done_v[0]} !== exp_done) begin
                n_err++;
                $display("FAIL rr_done cyc%0d: got %b want %b", k, {p0_done_v[0], p1_done_v[0]}, exp_done);
            end
            if (k % 3 == 0) begin
                n_vec++;
                if (mux_sel_v[0] !== 1'((k / 3) % 2)) begin
                    n_err++;
                    $display("FAIL rr_owner cyc%0d: got %b want %0d", k, mux_sel_v[0], (k / 3) % 2);
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) p1_req = 1'b0;
            tick();
            if (k % 3 == 0) begin
                n_vec++;
                if ({mem_req_v[1], mux_sel_v[1]} !== {1'b1, k != 9}) begin
                    n_err++;
                    $display("FAIL fp_owner cyc%0d: got req/sel %b want %b", k, {mem_req_v[1], mux_sel_v[1]}, {1'b1, k != 9});
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        p0_req = 1'b1;
        tick();
        n_vec++;
        if (mem_req_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_busy: got mem_req %b want 1", mem_req_v[0]);
        end
        rst = 1'b1; mem_ready = 1'b1;
        tick();
        rst = 1'b0; p0_req = 1'b0;
        n_vec++;
        if (dut_flags(0) !== 7'd0) begin
            n_err++;
            $display("FAIL midrst_abort: got %b want 0000000", dut_flags(0));
        end
        tick();
        n_vec++;
        if (dut_flags(0) !== 7'd0) begin
            n_err++;
            $display("FAIL midrst_nodone: got %b want 0000000", dut_flags(0));
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        p0_req = 1'b0;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_0000;
        tick();
        n_vec++;
        if (rsp_rdata_v[0] !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL to_preload: got %h want 12345678", rsp_rdata_v[0]);
        end
        p0_req = 1'b1;
        tick();
        p0_req = 1'b0;
        for (int k = 2; k <= c_TIMEOUT; k++) begin
            tick();
            n_vec++;
            if (mem_req_v[0] !== 1'b1) begin
                n_err++;
                $display("FAIL to_stall busy%0d: got mem_req %b want 1", k, mem_req_v[0]);
            end
        end
        tick();
        n_vec++;
        if ({mem_req_v[0], arb_timeout_v[0], p0_done_v[0]} !== (c_TO_EN ? 3'b011 : 3'b100)) begin
            n_err++;
            $display("FAIL to_abort: got req/to/done %b want %b",
                     {mem_req_v[0], arb_timeout_v[0], p0_done_v[0]}, c_TO_EN ? 3'b011 : 3'b100);
        end
        n_vec++;
        if (rsp_rdata_v[0] !== (c_TO_EN ? 32'd0 : 32'h1234_5678)) begin
            n_err++;
            $display("FAIL to_rdata: got %h want %h", rsp_rdata_v[0], c_TO_EN ? 32'd0 : 32'h1234_5678);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 79) == 0);
            p0_req    = ($urandom_range(0, 3) != 0);
            p1_req    = ($urandom_range(0, 2) != 0);
            p0_we     = 1'($urandom);
            p1_we     = 1'($urandom);
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            tick();
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (dut_flags(i) !== model_flags(i)) begin
                    n_err++;
                    $display("FAIL rand_flags inst%0d cyc%0d: got %b want %b", i, k, dut_flags(i), model_flags(i));
                end
                n_vec++;
                if (rsp_rdata_v[i] !== m_rd[i]) begin
                    n_err++;
                    $display("FAIL rand_rdata inst%0d cyc%0d: got %h want %h", i, k, rsp_rdata_v[i], m_rd[i]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_busy();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
